// File: rtl/rvvi_trace_tx.sv
// RVVI trace transmitter for one hart with a single retire slot. Each retirement
// record is held until its successor or a halt supplies the next PC, then emitted.
module rvvi_trace_tx #(
  parameter int ILEN = 32,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ret_valid,
  output logic                 ret_ready,
  input  logic [XLEN-1:0]      ret_pc,
  input  logic [ILEN-1:0]      ret_insn,
  input  logic                 ret_trap,
  input  logic [1:0]           ret_mode,
  input  logic [1:0]           ret_ixl,
  input  logic                 ret_rd_we,
  input  logic [4:0]           ret_rd,
  input  logic [XLEN-1:0]      ret_rd_data,
  input  logic                 ret_csr_we,
  input  logic [11:0]          ret_csr_addr,
  input  logic [XLEN-1:0]      ret_csr_data,
  input  logic                 int_taken,
  input  logic                 halt_req,
  input  logic [XLEN-1:0]      halt_pc,
  input  logic                 resume,
  output logic                 valid,
  output logic [63:0]          order,
  output logic [ILEN-1:0]      insn,
  output logic                 trap,
  output logic                 halt,
  output logic                 intr,
  output logic [1:0]           mode,
  output logic [1:0]           ixl,
  output logic [XLEN-1:0]      pc_rdata,
  output logic [XLEN-1:0]      pc_wdata,
  output logic [32*XLEN-1:0]   x_wdata,
  output logic [31:0]          x_wb,
  output logic [11:0]          csr_addr,
  output logic [XLEN-1:0]      csr_wdata,
  output logic                 csr_wb
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state_r;
  logic [63:0]       cnt_r;
  logic              pend_r;
  logic              last_trap_r;

  logic [XLEN-1:0]   h_pc_r;
  logic [ILEN-1:0]   h_insn_r;
  logic              h_trap_r;
  logic [1:0]        h_mode_r;
  logic [1:0]        h_ixl_r;
  logic              h_rd_we_r;
  logic [4:0]        h_rd_r;
  logic [XLEN-1:0]   h_rd_data_r;
  logic              h_csr_we_r;
  logic [11:0]       h_csr_addr_r;
  logic [XLEN-1:0]   h_csr_data_r;
  logic              h_intr_r;

  logic              accept_s;
  logic              emit_s;
  logic              intr_s;
  logic [XLEN-1:0]   next_pc_s;

  // Halt has priority over an offered record, so it also gates the handshake.
  assign ret_ready = !reset && (state_r != HALTED) && !halt_req;

  // Handshake, emission trigger and the successor PC of the held record.
  always_comb begin
    accept_s  = ret_valid && ret_ready;
    emit_s    = (state_r == HOLD) && (halt_req || accept_s);
    intr_s    = last_trap_r || int_taken || pend_r;
    if (halt_req) begin
      next_pc_s = halt_pc;
    end else begin
      next_pc_s = ret_pc;
    end
  end

  // FSM, hold register, shadow GPR file and registered trace outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= EMPTY;
      cnt_r        <= 64'd1;
      pend_r       <= 1'b0;
      last_trap_r  <= 1'b0;
      h_pc_r       <= '0;
      h_insn_r     <= '0;
      h_trap_r     <= 1'b0;
      h_mode_r     <= 2'd0;
      h_ixl_r      <= 2'd0;
      h_rd_we_r    <= 1'b0;
      h_rd_r       <= 5'd0;
      h_rd_data_r  <= '0;
      h_csr_we_r   <= 1'b0;
      h_csr_addr_r <= 12'd0;
      h_csr_data_r <= '0;
      h_intr_r     <= 1'b0;
      valid        <= 1'b0;
      order        <= 64'd0;
      insn         <= '0;
      trap         <= 1'b0;
      halt         <= 1'b0;
      intr         <= 1'b0;
      mode         <= 2'd0;
      ixl          <= 2'd0;
      pc_rdata     <= '0;
      pc_wdata     <= '0;
      x_wdata      <= '0;
      x_wb         <= 32'd0;
      csr_addr     <= 12'd0;
      csr_wdata    <= '0;
      csr_wb       <= 1'b0;
    end else begin
      valid  <= 1'b0;
      x_wb   <= 32'd0;
      csr_wb <= 1'b0;

      if (emit_s) begin
        valid     <= 1'b1;
        order     <= cnt_r;
        cnt_r     <= cnt_r + 64'd1;
        insn      <= h_insn_r;
        trap      <= h_trap_r;
        halt      <= halt_req;
        intr      <= h_intr_r;
        mode      <= h_mode_r;
        ixl       <= h_ixl_r;
        pc_rdata  <= h_pc_r;
        pc_wdata  <= next_pc_s;
        csr_addr  <= h_csr_addr_r;
        csr_wdata <= h_csr_data_r;
        csr_wb    <= h_csr_we_r;
        // x0 is never written, so its slot and write flag stay zero.
        for (int i = 1; i < 32; i++) begin
          if (h_rd_we_r && (h_rd_r == 5'(i))) begin
            x_wdata[i*XLEN +: XLEN] <= h_rd_data_r;
            x_wb[i]                 <= 1'b1;
          end
        end
      end

      if (accept_s) begin
        h_pc_r       <= ret_pc;
        h_insn_r     <= ret_insn;
        h_trap_r     <= ret_trap;
        h_mode_r     <= ret_mode;
        h_ixl_r      <= ret_ixl;
        h_rd_we_r    <= ret_rd_we && !ret_trap;
        h_rd_r       <= ret_rd;
        h_rd_data_r  <= ret_rd_data;
        h_csr_we_r   <= ret_csr_we && !ret_trap;
        h_csr_addr_r <= ret_csr_addr;
        h_csr_data_r <= ret_csr_data;
        h_intr_r     <= intr_s;
        last_trap_r  <= ret_trap;
        pend_r       <= 1'b0;
      end else if (int_taken) begin
        pend_r <= 1'b1;
      end

      case (state_r)
        EMPTY: begin
          if (halt_req) begin
            state_r <= HALTED;
          end else if (accept_s) begin
            state_r <= HOLD;
          end
        end
        HOLD: begin
          if (halt_req) begin
            state_r <= HALTED;
          end
        end
        HALTED: begin
          if (resume) begin
            state_r <= EMPTY;
          end
        end
        default: state_r <= EMPTY;
      endcase
    end
  end

endmodule
